// File: rtl/disk_xfer_engine.sv
// disk_xfer_engine
//   Multi-drive emulated-disk transfer engine. Accepts a decoded command,
//   validates it against the configured geometry, models a timed seek and
//   then moves words between the shared DMA master and block-RAM disks.
//   READ moves disk -> memory, WRITE moves memory -> disk (zero-filling the
//   rest of a partial sector), WRITE_CHECK compares memory with disk.
//
// Ports
//   clk, RINIT              clock, asynchronous active-high reset
//   cmd_go/func/drive/...   command strobe and latched command fields
//   write_lock              per-drive write protect
//   busy, done, err         status; err = {OVR, WLO, NXM, NXD, NXC, NXS, WCE}
//   cur_*                   live transfer registers for register readback
//   dma_*                   request/response handshake with the DMA master
module disk_xfer_engine #(
    parameter int DRIVES       = 2,
    parameter int CYLINDERS    = 10,
    parameter int SURFACES     = 2,
    parameter int SECTORS      = 12,
    parameter int SECTOR_WORDS = 256,
    parameter int SEEK_CYCLES  = 16
) (
    input  logic        clk,
    input  logic        RINIT,
    input  logic        cmd_go,
    input  logic [2:0]  cmd_func,
    input  logic [2:0]  cmd_drive,
    input  logic [7:0]  cmd_cyl,
    input  logic        cmd_sur,
    input  logic [3:0]  cmd_sec,
    input  logic [15:0] cmd_wc,
    input  logic [20:0] cmd_ba,
    input  logic        cmd_inh_ba,
    input  logic [7:0]  write_lock,
    output logic        busy,
    output logic        done,
    output logic [6:0]  err,
    output logic [7:0]  cur_cyl,
    output logic        cur_sur,
    output logic [3:0]  cur_sec,
    output logic [15:0] cur_wc,
    output logic [20:0] cur_ba,
    output logic        dma_read_req,
    output logic        dma_write_req,
    output logic [21:0] dma_addr,
    output logic [15:0] dma_wdata,
    input  logic [15:0] dma_rdata,
    input  logic        dma_complete,
    input  logic        dma_nxm
);

    localparam int SAW           = $clog2(SECTOR_WORDS);
    localparam int LBA_PER_DRIVE = CYLINDERS * SURFACES * SECTORS;
    localparam int RAM_WORDS     = DRIVES * LBA_PER_DRIVE * SECTOR_WORDS;
    localparam int AW            = $clog2(RAM_WORDS);
    localparam int DIW           = (DRIVES > 1) ? $clog2(DRIVES) : 1;

    localparam logic [2:0] F_WRITE  = 3'b001;
    localparam logic [2:0] F_READ   = 3'b010;
    localparam logic [2:0] F_WCHECK = 3'b011;

    localparam int E_WCE = 0;
    localparam int E_NXS = 1;
    localparam int E_NXC = 2;
    localparam int E_NXD = 3;
    localparam int E_NXM = 4;
    localparam int E_WLO = 5;
    localparam int E_OVR = 6;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_SEEK, S_PREFETCH, S_XFER, S_FILL, S_DONE
    } state_t;

    state_t          r_state, w_state_next;
    logic [2:0]      r_func, w_func_next;
    logic [2:0]      r_drive, w_drive_next;
    logic [7:0]      r_cyl, w_cyl_next;
    logic            r_sur, w_sur_next;
    logic [3:0]      r_sec, w_sec_next;
    logic [15:0]     r_wc, w_wc_next;
    logic [20:0]     r_ba, w_ba_next;
    logic            r_inh, w_inh_next;
    logic [6:0]      r_err, w_err_next;
    logic [SAW-1:0]  r_saddr, w_saddr_next;
    logic [23:0]     r_seek_cnt, w_seek_next;

    // RAM port
    logic [15:0]     r_mem [RAM_WORDS];
    logic [15:0]     r_ram_q;
    logic            r_q_vld;
    logic [AW-1:0]   w_ram_addr;
    logic            w_mem_we;
    logic [15:0]     w_mem_wdata;

    // Per-drive head position and seek distance
    logic [DRIVES-1:0][7:0] w_head_cyl;
    logic [7:0]      w_head;
    logic [7:0]      w_dist;
    logic [23:0]     w_seek_load;
    logic            w_seek_end;

    // Disk address one sector on, saturating at the last sector
    logic            w_at_last_sec;
    logic [7:0]      w_adv_cyl;
    logic            w_adv_sur;
    logic [3:0]      w_adv_sec;

    logic [15:0]     w_wc_inc;
    logic            w_xfer_func;
    logic            w_ovr;

    assign w_ram_addr = AW'((32'(r_drive) * LBA_PER_DRIVE
                             + 32'(r_cyl) * (SURFACES * SECTORS)
                             + 32'(r_sur) * SECTORS
                             + 32'(r_sec)) * SECTOR_WORDS
                            + 32'(r_saddr));

    assign w_head      = w_head_cyl[r_drive[DIW-1:0]];
    assign w_dist      = (r_cyl >= w_head) ? (r_cyl - w_head) : (w_head - r_cyl);
    assign w_seek_load = 24'(w_dist) * 24'(SEEK_CYCLES);
    assign w_seek_end  = (r_state == S_SEEK) && (r_seek_cnt == 24'd0);
    assign w_wc_inc    = r_wc + 16'd1;
    assign w_xfer_func = (r_func == F_WRITE) || (r_func == F_READ) || (r_func == F_WCHECK);

    assign cur_cyl   = r_cyl;
    assign cur_sur   = r_sur;
    assign cur_sec   = r_sec;
    assign cur_wc    = r_wc;
    assign cur_ba    = r_ba;
    assign err       = r_err;
    assign dma_addr  = {r_ba, 1'b0};
    // Read data is masked until the first prefetch so reset leaves it at 0.
    assign dma_wdata = r_q_vld ? r_ram_q : 16'd0;

    // The head position only moves at the end of a seek.
    for (genvar gi = 0; gi < DRIVES; gi++) begin : g_head
        logic [7:0] r_head;
        always_ff @(posedge clk or posedge RINIT) begin
            if (RINIT) begin
                r_head <= 8'd0;
            end else if (w_seek_end && (r_drive == 3'(gi))) begin
                r_head <= r_cyl;
            end
        end
        assign w_head_cyl[gi] = r_head;
    end

    always_comb begin
        w_at_last_sec = (r_cyl == 8'(CYLINDERS - 1)) && (r_sur == 1'(SURFACES - 1))
                        && (r_sec == 4'(SECTORS - 1));
        w_adv_cyl = r_cyl;
        w_adv_sur = r_sur;
        w_adv_sec = r_sec;
        if (!w_at_last_sec) begin
            if (r_sec != 4'(SECTORS - 1)) begin
                w_adv_sec = r_sec + 4'd1;
            end else begin
                w_adv_sec = 4'd0;
                if (r_sur != 1'(SURFACES - 1)) begin
                    w_adv_sur = r_sur + 1'b1;
                end else begin
                    w_adv_sur = 1'b0;
                    w_adv_cyl = r_cyl + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge RINIT) begin
        if (RINIT) begin
            r_state    <= S_IDLE;
            r_func     <= 3'd0;
            r_drive    <= 3'd0;
            r_cyl      <= 8'd0;
            r_sur      <= 1'b0;
            r_sec      <= 4'd0;
            r_wc       <= 16'd0;
            r_ba       <= 21'd0;
            r_inh      <= 1'b0;
            r_err      <= 7'd0;
            r_saddr    <= '0;
            r_seek_cnt <= 24'd0;
            r_q_vld    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_func     <= w_func_next;
            r_drive    <= w_drive_next;
            r_cyl      <= w_cyl_next;
            r_sur      <= w_sur_next;
            r_sec      <= w_sec_next;
            r_wc       <= w_wc_next;
            r_ba       <= w_ba_next;
            r_inh      <= w_inh_next;
            r_err      <= w_err_next;
            r_saddr    <= w_saddr_next;
            r_seek_cnt <= w_seek_next;
            if (r_state == S_PREFETCH) begin
                r_q_vld <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_ram_addr] <= w_mem_wdata;
        end
        if (r_state == S_PREFETCH) begin
            r_ram_q <= r_mem[w_ram_addr];
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_func_next   = r_func;
        w_drive_next  = r_drive;
        w_cyl_next    = r_cyl;
        w_sur_next    = r_sur;
        w_sec_next    = r_sec;
        w_wc_next     = r_wc;
        w_ba_next     = r_ba;
        w_inh_next    = r_inh;
        w_err_next    = r_err;
        w_saddr_next  = r_saddr;
        w_seek_next   = r_seek_cnt;
        w_mem_we      = 1'b0;
        w_mem_wdata   = 16'd0;
        w_ovr         = 1'b0;
        busy          = (r_state != S_IDLE) && (r_state != S_DONE);
        done          = (r_state == S_DONE);
        dma_write_req = (r_state == S_XFER) && (r_func == F_READ);
        dma_read_req  = (r_state == S_XFER) && (r_func != F_READ);

        case (r_state)
            // busy is already low in DONE, so a strobe there is accepted too.
            S_IDLE, S_DONE: begin
                w_state_next = S_IDLE;
                if (cmd_go) begin
                    w_func_next  = cmd_func;
                    w_drive_next = cmd_drive;
                    w_cyl_next   = cmd_cyl;
                    w_sur_next   = cmd_sur;
                    w_sec_next   = cmd_sec;
                    w_wc_next    = cmd_wc;
                    w_ba_next    = cmd_ba;
                    w_inh_next   = cmd_inh_ba;
                    w_err_next   = 7'd0;
                    w_saddr_next = '0;
                    w_state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                w_state_next = S_DONE;
                if (32'(r_drive) >= DRIVES) begin
                    w_err_next[E_NXD] = 1'b1;
                end else if (32'(r_cyl) >= CYLINDERS) begin
                    w_err_next[E_NXC] = 1'b1;
                end else if (32'(r_sec) >= SECTORS) begin
                    w_err_next[E_NXS] = 1'b1;
                end else if ((r_func == F_WRITE) && write_lock[r_drive]) begin
                    w_err_next[E_WLO] = 1'b1;
                end else begin
                    w_seek_next  = w_seek_load;
                    w_state_next = S_SEEK;
                end
            end
            S_SEEK: begin
                if (r_seek_cnt == 24'd0) begin
                    w_state_next = (!w_xfer_func || (r_wc == 16'd0)) ? S_DONE : S_PREFETCH;
                end else begin
                    w_seek_next = r_seek_cnt - 24'd1;
                end
            end
            S_PREFETCH: begin
                w_state_next = S_XFER;
            end
            S_XFER: begin
                // NXM takes precedence over a coincident completion.
                if (dma_nxm) begin
                    w_err_next[E_NXM] = 1'b1;
                    w_state_next      = S_DONE;
                end else if (dma_complete) begin
                    if (r_func == F_WRITE) begin
                        w_mem_we    = 1'b1;
                        w_mem_wdata = dma_rdata;
                    end
                    w_wc_next    = w_wc_inc;
                    w_saddr_next = r_saddr + SAW'(1);
                    if (!r_inh) begin
                        w_ba_next = r_ba + 21'd1;
                    end
                    if (r_saddr == SAW'(SECTOR_WORDS - 1)) begin
                        if (w_at_last_sec && (w_wc_inc != 16'd0)) begin
                            w_err_next[E_OVR] = 1'b1;
                            w_ovr             = 1'b1;
                        end
                        w_cyl_next = w_adv_cyl;
                        w_sur_next = w_adv_sur;
                        w_sec_next = w_adv_sec;
                    end
                    if ((r_func == F_WCHECK) && (dma_rdata != dma_wdata)) begin
                        w_err_next[E_WCE] = 1'b1;
                        w_state_next      = S_DONE;
                    end else if (w_ovr) begin
                        w_state_next = S_DONE;
                    end else if (w_wc_inc == 16'd0) begin
                        w_state_next = ((r_func == F_WRITE) && (r_saddr != SAW'(SECTOR_WORDS - 1)))
                                       ? S_FILL : S_DONE;
                    end else begin
                        w_state_next = S_PREFETCH;
                    end
                end
            end
            S_FILL: begin
                w_mem_we     = 1'b1;
                w_mem_wdata  = 16'd0;
                w_saddr_next = r_saddr + SAW'(1);
                if (r_saddr == SAW'(SECTOR_WORDS - 1)) begin
                    w_cyl_next   = w_adv_cyl;
                    w_sur_next   = w_adv_sur;
                    w_sec_next   = w_adv_sec;
                    w_state_next = S_DONE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule
